key_conditioner: RTL and testbench

- Upstream conditioning stage for the digital-clock top: takes the raw board push-buttons (set_mod, left, right, up, down) and produces clean, single-clock-domain signals.
- Per key it produces:
  - a debounced level, so set_mod can be used as a mode level;
  - one-cycle press and release pulses, so the position/adjust logic runs on clk instead of on raw button edges.
- Everything runs on the 100 MHz system clock. No derived clocks.

---
 rtl/key_conditioner.sv | 186 ++++++++++++++++++
 tb/tb_key_conditioner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises, debounces and edge-detects the board keys.
// Per key: 2-flop synchroniser, debounce FSM with a stable-cycle counter,
// registered one-cycle press/release pulses and a debounced level.
// Optional macro KEY_AUTOREPEAT_EN adds held-key auto-repeat press pulses
// on keys selected by REPEAT_MASK.

module key_lane #(
  parameter int DEBOUNCE_CYCLES = 2000000
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter bit RPT_EN        = 1'b0
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  // state[1] doubles as the debounced level, so level is a plain flop output
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_WAIT = 2'b11
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           press_nxt, rel_nxt, rpt_fire;
  logic           diff, done;

  assign level = state[1];
  assign diff  = s ^ state[1];
  assign done  = (cnt == CW'(DEBOUNCE_CYCLES - 1));

  // state, debounce counter and registered pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      press <= press_nxt | rpt_fire;
      rel   <= rel_nxt;
    end
  end

  // next state: count while synchronised input disagrees with the level,
  // any agreeing cycle drops back and clears the count
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (diff) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = cnt + 1'b1;
        end
      end
      PRESS_WAIT: begin
        if (!diff) begin
          state_nxt = IDLE;
        end else if (done) begin
          state_nxt = HELD;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (diff) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = cnt + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (!diff) begin
          state_nxt = HELD;
        end else if (done) begin
          state_nxt = IDLE;
          rel_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  if (RPT_EN) begin : g_rpt
    logic [RW-1:0] rpt_cnt;
    logic          rpt_phase;  // 0: waiting for first repeat, 1: periodic

    // only fires while staying in HELD, so it can never meet a release pulse
    assign rpt_fire = (state == HELD) && !diff &&
                      (rpt_phase ? (rpt_cnt == RW'(REPEAT_PERIOD - 1))
                                 : (rpt_cnt == RW'(REPEAT_DELAY - 1)));

    // repeat timer runs only while held, restarts on every pulse
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b0;
      end else if (state != HELD || diff) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b0;
      end else if (rpt_fire) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end else begin : g_no_rpt
    assign rpt_fire = 1'b0;
  end
`else
  assign rpt_fire = 1'b0;
`endif
endmodule

module key_conditioner #(
  parameter int                N_KEYS          = 5,
  parameter int                DEBOUNCE_CYCLES = 2000000,
  parameter int                REPEAT_DELAY    = 50000000,
  parameter int                REPEAT_PERIOD   = 10000000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK     = 5'b11000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);
  logic [N_KEYS-1:0] sync_q1, sync_q2;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_cfg_bad
    $error("key_conditioner: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* >= 1");
  end

  // two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
    key_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .RPT_EN         (REPEAT_MASK[i])
`endif
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .s    (sync_q2[i]),
      .level(key_level[i]),
      .press(key_press[i]),
      .rel  (key_release[i])
    );
  end
endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=8,
// REPEAT_DELAY=40, REPEAT_PERIOD=10. Cycle k = k edges after the drive.
module tb_key_conditioner;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] key_raw = '0;
  logic [4:0] key_level, key_press, key_release;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         npress, nrel;
  logic [4:0] acc;

`ifdef KEY_AUTOREPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  key_conditioner #(
    .N_KEYS(5), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(40),
    .REPEAT_PERIOD(10), .REPEAT_MASK(5'b11000)
  ) dut (
    .clk(clk), .reset(reset), .key_raw(key_raw),
    .key_level(key_level), .key_press(key_press), .key_release(key_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    key_raw = '0;
    repeat (14) tick();
    chk("idle", {key_level, key_press, key_release}, 0);
  endtask

  initial begin
    // reset with all keys held: outputs clear immediately
    key_raw = 5'b11111;
    #2;
    chk("rst_level", key_level, 0);
    chk("rst_press", key_press, 0);
    chk("rst_rel", key_release, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold", {key_level, key_press, key_release}, 0);
    reset = 1'b0;
    cyc = 0;
    repeat (9) tick();
    chk("rst_c9_level", key_level, 0);
    tick();
    chk("rst_c10_level", key_level, 5'b11111);
    chk("rst_c10_press", key_press, 5'b11111);
    tick();
    chk("rst_c11_press", key_press, 0);
    key_raw = '0;
    cyc = 0;
    repeat (10) tick();
    chk("rst_rel_c10", key_release, 5'b11111);
    chk("rst_rel_level", key_level, 0);
    settle();

    // clean press on key 1, release driven at cycle 30
    cyc = 0; npress = 0; nrel = 0;
    key_raw[1] = 1'b1;
    while (cyc < 44) begin
      tick();
      npress += int'(key_press[1]);
      nrel   += int'(key_release[1]);
      if (cyc == 9)  chk("clean_c9_level", key_level, 0);
      if (cyc == 10) chk("clean_c10", {key_level, key_press}, {5'b00010, 5'b00010});
      if (cyc == 39) chk("clean_c39_rel", key_release, 0);
      if (cyc == 40) chk("clean_c40", {key_level, key_release}, {5'b00000, 5'b00010});
      if (cyc == 30) key_raw[1] = 1'b0;
    end
    chk("clean_npress", npress, 1);
    chk("clean_nrel", nrel, 1);
    settle();

    // 7-cycle glitch on key 3 is rejected
    cyc = 0; acc = '0;
    key_raw[3] = 1'b1;
    while (cyc < 20) begin
      tick();
      acc |= key_level | key_press | key_release;
      if (cyc == 7) key_raw[3] = 1'b0;
    end
    chk("glitch7", acc, 0);
    settle();

    // 8-cycle pulse is just long enough to be accepted
    cyc = 0; npress = 0; nrel = 0;
    key_raw[3] = 1'b1;
    while (cyc < 22) begin
      tick();
      npress += int'(key_press[3]);
      nrel   += int'(key_release[3]);
      if (cyc == 10) chk("pulse8_press", key_press, 5'b01000);
      if (cyc == 18) chk("pulse8_rel", key_release, 5'b01000);
      if (cyc == 8) key_raw[3] = 1'b0;
    end
    chk("pulse8_counts", {npress[7:0], nrel[7:0]}, 16'h0101);
    settle();

    // bounce train of 3-cycle pulses, stable high from cycle 12
    cyc = 0; npress = 0;
    key_raw[3] = 1'b1;
    while (cyc < 30) begin
      tick();
      npress += int'(key_press[3]);
      if (cyc == 22) chk("bounce_c22", key_press, 5'b01000);
      key_raw[3] = (cyc >= 12) || ((cyc % 6) < 3);
    end
    chk("bounce_npress", npress, 1);
    settle();

    // simultaneous keys 2 and 4
    cyc = 0; acc = '0;
    key_raw = 5'b10100;
    while (cyc < 12) begin
      tick();
      if (cyc != 10) acc |= key_press;
      if (cyc == 10) chk("simul_press", key_press, 5'b10100);
      if (cyc == 10) chk("simul_level", key_level, 5'b10100);
    end
    chk("simul_other", acc, 0);
    settle();

    // reset at cycle 5 for two cycles restarts the count
    cyc = 0; npress = 0;
    key_raw[0] = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("midrst_out", {key_level, key_press, key_release}, 0);
    tick();
    tick();
    reset = 1'b0;
    while (cyc < 20) begin
      tick();
      npress += int'(key_press[0]);
      if (cyc == 10) chk("midrst_c10", key_press, 0);
      if (cyc == 16) chk("midrst_c16", key_level, 0);
      if (cyc == 17) chk("midrst_c17", {key_level, key_press}, {5'b00001, 5'b00001});
    end
    chk("midrst_npress", npress, 1);
    settle();

    // hold keys 1 and 3; only key 3 may repeat, and only with the macro
    cyc = 0; npress = 0;
    key_raw = 5'b01010;
    while (cyc < 116) begin
      tick();
      chk("rpt_press3", key_press[3],
          (cyc == 10) || (REP && cyc >= 50 && cyc <= 100 && (cyc % 10) == 0));
      npress += int'(key_press[1]);
      if (cyc == 112) chk("rpt_rel", key_release, 5'b01010);
      if (cyc == 111) chk("rpt_rel_early", key_release, 0);
      if (cyc == 102) key_raw = '0;
    end
    chk("rpt_key1_npress", npress, 1);
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
